// File: rtl/div_pkg.sv
// Shared definitions for the Booth-style sequential divider.
//   state_t  : FSM state encoding (IDLE, CALC, FIX)
//   MAG_W    : working width of the magnitude helper
//   twos_mag : two's-complement magnitude of a sign-extended value; callers
//              narrow the result back to their own operand width with a cast.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int MAG_W = 64;

    // |v| for a sign-extended operand. |most-negative| lands on 2^(w-1),
    // which is still representable as an unsigned w-bit magnitude.
    function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] v);
        return v[MAG_W-1] ? ((~v) + {{(MAG_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/sum_sub.sv
// Ripple adder/subtractor shared with the Booth multiplier.
//   a, b : operands (W bits)
//   sub  : 0 -> s = a + b, 1 -> s = a + ~b + 1 = a - b
//   s    : W-bit result
//   cout : carry out of the top bit (no-borrow flag when subtracting)
module sum_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] b_eff;

    assign b_eff     = sub ? ~b : b;
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/bth_div.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Works on operand magnitudes in an A/Q/M register set, then fixes signs:
// quotient truncates toward zero, remainder follows the dividend's sign.
//   clk, rst      : clock, synchronous active-low reset
//   load          : start request, accepted only in IDLE
//   inp_q, inp_m  : dividend / divisor (two's complement)
//   quot, rem     : registered results, held until the next result
//   busy          : operation in flight (never high together with done)
//   done          : one-cycle pulse when results update
//   dz, ovf       : divide-by-zero / most-negative-by-minus-one flags
module bth_div
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] inp_q,
    input  logic [WIDTH-1:0] inp_m,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, q_reg, m_reg, dvd_reg;
    logic             sign_q, sign_m, dz_pend, ovf_pend;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] a_sh, q_sh;
    logic [WIDTH:0]   trial;
    logic             trial_unused_co;
    logic [WIDTH-1:0] q_neg, a_neg;
    logic [MAG_W-1:0] q_sext, m_sext;
    logic             m_zero, q_min, m_neg1;

    assign {a_sh, q_sh} = {a_reg, q_reg} << 1;

    // Trial subtraction on zero-extended values: the top bit is the borrow.
    sum_sub #(.W(WIDTH + 1)) u_trial (
        .a    ({1'b0, a_sh}),
        .b    ({1'b0, m_reg}),
        .sub  (1'b1),
        .s    (trial),
        .cout (trial_unused_co)
    );

    assign q_sext = {{(MAG_W-WIDTH){inp_q[WIDTH-1]}}, inp_q};
    assign m_sext = {{(MAG_W-WIDTH){inp_m[WIDTH-1]}}, inp_m};
    assign m_zero = (inp_m == '0);
    assign q_min  = (inp_q == {1'b1, {(WIDTH-1){1'b0}}});
    assign m_neg1 = (inp_m == '1);

    assign q_neg  = (~q_reg) + WIDTH'(1);
    assign a_neg  = (~a_reg) + WIDTH'(1);

    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (load) state_nxt = m_zero ? FIX : CALC;
            CALC:    if (count == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg    <= '0;
            q_reg    <= '0;
            m_reg    <= '0;
            dvd_reg  <= '0;
            sign_q   <= 1'b0;
            sign_m   <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
            count    <= '0;
            quot     <= '0;
            rem      <= '0;
            done     <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        a_reg    <= '0;
                        q_reg    <= WIDTH'(twos_mag(q_sext));
                        m_reg    <= WIDTH'(twos_mag(m_sext));
                        dvd_reg  <= inp_q;
                        sign_q   <= inp_q[WIDTH-1];
                        sign_m   <= inp_m[WIDTH-1];
                        dz_pend  <= m_zero;
                        // Natural wrap already yields 100..0 / 0; only the flag is extra.
                        ovf_pend <= q_min && m_neg1;
                        count    <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        a_reg <= trial[WIDTH-1:0];
                        q_reg <= {q_sh[WIDTH-1:1], 1'b1};
                    end else begin
                        a_reg <= a_sh;
                        q_reg <= q_sh;
                    end
                    count <= count - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    dz   <= dz_pend;
                    ovf  <= ovf_pend;
                    if (dz_pend) begin
                        quot <= '1;
                        rem  <= dvd_reg;
                    end else begin
                        quot <= (sign_q ^ sign_m) ? q_neg : q_reg;
                        rem  <= sign_q ? a_neg : a_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
